// File: rtl/stack_param.sv
// stack_param: register LIFO with registered head, DEPTH tail cells, peek port, occupancy and sticky error flags.
module stack_param #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 18,
   parameter logic [WIDTH-1:0] FILL = WIDTH'(16'h55aa),
   localparam int CW = $clog2(DEPTH+2),
   localparam int IW = $clog2(DEPTH+1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             we,
   input  logic [1:0]       delta,
   input  logic [WIDTH-1:0] wd,
   output logic [WIDTH-1:0] rd,
   output logic [WIDTH-1:0] nos,
   input  logic [IW-1:0]    peek_idx,
   output logic [WIDTH-1:0] peek_data,
   output logic [CW-1:0]    depth,
   output logic             overflow,
   output logic             underflow,
   input  logic             clr_err
);
   logic [WIDTH-1:0] h_q, h_d;
   logic [WIDTH-1:0] t_q [DEPTH];
   logic [WIDTH-1:0] t_d [DEPTH];
   logic [WIDTH-1:0] up [DEPTH+1];
   logic [WIDTH-1:0] ext [DEPTH+2];
   logic [CW-1:0]    d_q, d_d;
   logic             ovf_q, ovf_d, unf_q, unf_d;
   logic             push, pop1, pop2, full, ovf_ev, unf_ev;

   // up: whole stack head-first (push image and peek view); ext: tail padded with FILL for pops
   always_comb begin
      up[0] = h_q;
      for (int i = 0; i < DEPTH; i++) up[i+1] = t_q[i];
      for (int i = 0; i < DEPTH; i++) ext[i] = t_q[i];
      ext[DEPTH] = FILL;
      ext[DEPTH+1] = FILL;
      push = delta == 2'b01;
      pop1 = delta == 2'b11;
      pop2 = delta == 2'b10;
      full = d_q == CW'(DEPTH+1);
      h_d = we ? wd : pop1 ? ext[0] : pop2 ? ext[1] : h_q;
      for (int i = 0; i < DEPTH; i++)
         t_d[i] = push ? up[i] : pop1 ? ext[i+1] : pop2 ? ext[i+2] : t_q[i];
      ovf_ev = push && full;
      unf_ev = (pop1 && d_q == '0) || (pop2 && d_q < CW'(2));
      d_d = push ? (full ? d_q : d_q + CW'(1)) :
            pop1 ? (unf_ev ? '0 : d_q - CW'(1)) :
            pop2 ? (unf_ev ? '0 : d_q - CW'(2)) : d_q;
      ovf_d = (ovf_q && !clr_err) || ovf_ev;
      unf_d = (unf_q && !clr_err) || unf_ev;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         h_q <= '0;
         t_q <= '{default: FILL};
         d_q <= '0;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         h_q <= h_d;
         t_q <= t_d;
         d_q <= d_d;
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

   assign rd = h_q;
   assign nos = t_q[0];
   assign peek_data = 32'(peek_idx) > DEPTH ? FILL : up[peek_idx];
   assign depth = d_q;
   assign overflow = ovf_q;
   assign underflow = unf_q;
endmodule

// File: tb/tb_stack_param.sv
// tb_stack_param: directed checks of stack_param at default size and at WIDTH=32, DEPTH=4.
module tb_stack_param;
   logic clk = 0;
   always #5 clk = ~clk;

   logic        r1, we1, clr1;
   logic [1:0]  dl1;
   logic [15:0] wd1, rd1, nos1, pk1;
   logic [4:0]  pi1;
   logic [4:0]  dp1;
   logic        ov1, un1;

   logic        r2, we2, clr2;
   logic [1:0]  dl2;
   logic [31:0] wd2, rd2, nos2, pk2;
   logic [2:0]  pi2;
   logic [2:0]  dp2;
   logic        ov2, un2;

   int tests = 0, fails = 0;

   stack_param u16 (.clk(clk), .reset(r1), .we(we1), .delta(dl1), .wd(wd1), .rd(rd1), .nos(nos1),
      .peek_idx(pi1), .peek_data(pk1), .depth(dp1), .overflow(ov1), .underflow(un1), .clr_err(clr1));

   stack_param #(.WIDTH(32), .DEPTH(4)) u32 (.clk(clk), .reset(r2), .we(we2), .delta(dl2), .wd(wd2),
      .rd(rd2), .nos(nos2), .peek_idx(pi2), .peek_data(pk2), .depth(dp2), .overflow(ov2),
      .underflow(un2), .clr_err(clr2));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic op1(input logic w, input logic [1:0] d, input logic [15:0] v, input logic c);
      we1 = w; dl1 = d; wd1 = v; clr1 = c;
      @(posedge clk); #1;
      we1 = 0; dl1 = 0; clr1 = 0;
   endtask

   task automatic op2(input logic w, input logic [1:0] d, input logic [31:0] v);
      we2 = w; dl2 = d; wd2 = v;
      @(posedge clk); #1;
      we2 = 0; dl2 = 0;
   endtask

   initial begin
      r1 = 1; we1 = 0; dl1 = 0; wd1 = 0; clr1 = 0; pi1 = 0;
      r2 = 1; we2 = 0; dl2 = 0; wd2 = 0; clr2 = 0; pi2 = 0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_rd", rd1, 0);
      check("rst_nos", nos1, 16'h55aa);
      check("rst_depth", dp1, 0);
      check("rst_flags", {ov1, un1}, 0);
      r1 = 0; r2 = 0;

      op1(1, 2'b01, 16'h1, 0);
      op1(1, 2'b01, 16'h2, 0);
      op1(1, 2'b01, 16'h3, 0);
      pi1 = 2; #1;
      check("push3_rd", rd1, 3);
      check("push3_nos", nos1, 2);
      check("push3_peek2", pk1, 1);
      check("push3_depth", dp1, 3);
      check("push3_flags", {ov1, un1}, 0);

      op1(0, 2'b10, 16'h0, 0);
      check("pop2_rd", rd1, 1);
      check("pop2_nos", nos1, 0);
      check("pop2_depth", dp1, 1);
      op1(1, 2'b11, 16'h7, 0);
      check("popw_rd", rd1, 7);
      check("popw_depth", dp1, 0);
      check("popw_unf", un1, 0);

      op1(0, 2'b11, 16'h0, 0);
      check("unf_set", un1, 1);
      check("unf_depth", dp1, 0);
      check("unf_rd", rd1, 16'h55aa);
      op1(0, 2'b00, 16'h0, 1);
      check("clr_unf", un1, 0);
      op1(0, 2'b11, 16'h0, 1);
      check("clr_vs_set", un1, 1);
      op1(0, 2'b10, 16'h0, 1);
      check("pop2_empty_unf", un1, 1);
      check("pop2_empty_depth", dp1, 0);

      r1 = 1; @(posedge clk); #1; r1 = 0;
      for (int k = 1; k <= 19; k++) op1(1, 2'b01, 16'h1000 + 16'(k), 0);
      check("full_depth", dp1, 19);
      check("full_ovf", ov1, 0);
      op1(1, 2'b01, 16'h1014, 0);
      pi1 = 18; #1;
      check("ovf_set", ov1, 1);
      check("ovf_depth", dp1, 19);
      check("ovf_peek18", pk1, 16'h1002);
      pi1 = 19; #1;
      check("peek_oob", pk1, 16'h55aa);
      pi1 = 0; #1;
      check("peek_head", pk1, 16'h1014);

      op1(1, 2'b00, 16'hbeef, 0);
      check("hold_rd", rd1, 16'hbeef);
      check("hold_nos", nos1, 16'h1013);
      check("hold_depth", dp1, 19);
      op1(0, 2'b01, 16'h0, 0);
      check("dup_rd", rd1, 16'hbeef);
      check("dup_nos", nos1, 16'hbeef);
      op1(0, 2'b00, 16'h0, 1);
      check("clr_ovf", ov1, 0);

      op1(0, 2'b11, 16'h0, 0);
      op1(0, 2'b11, 16'h0, 0);
      r1 = 1; we1 = 1; dl1 = 2'b01; wd1 = 16'h1234;
      @(posedge clk); #1;
      r1 = 0; we1 = 0; dl1 = 0;
      pi1 = 5; #1;
      check("rstmv_rd", rd1, 0);
      check("rstmv_depth", dp1, 0);
      check("rstmv_peek5", pk1, 16'h55aa);
      check("rstmv_flags", {ov1, un1}, 0);

      op2(1, 2'b01, 32'h1);
      op2(1, 2'b01, 32'h2);
      op2(1, 2'b01, 32'h3);
      pi2 = 2; #1;
      check("w32_rd", rd2, 3);
      check("w32_nos", nos2, 2);
      check("w32_peek2", pk2, 1);
      check("w32_depth", dp2, 3);
      check("w32_flags", {ov2, un2}, 0);
      op2(1, 2'b01, 32'h4);
      op2(1, 2'b01, 32'h5);
      check("w32_full", {ov2, dp2}, {1'b0, 3'd5});
      op2(1, 2'b01, 32'h6);
      check("w32_ovf", {ov2, dp2}, {1'b1, 3'd5});
      op2(0, 2'b10, 32'h0);
      pi2 = 5; #1;
      check("w32_pop2_rd", rd2, 4);
      check("w32_pop2_nos", nos2, 3);
      check("w32_pop2_depth", dp2, 3);
      check("w32_peek_oob", pk2, 32'h55aa);
      pi2 = 4; #1;
      check("w32_peek_fill", pk2, 32'h55aa);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
